// File: rtl/axi_mem_slave.sv
// AXI4 responder backing a word-addressed 64-bit RAM for the JTAG debug bridge.
// Independent write (AW/W/B) and read (AR/R) engines share only the RAM array.
module axi_mem_slave #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [63:0]       s_axi_wdata,
    input  logic [7:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic              s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic              s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic              s_axi_rid,
    output logic [63:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [63:0] mem [DEPTH];

    // Reserved burst type, illegal wrap length, or beat wider than the bus.
    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        return (burst == 2'b11) || (size > 3'd3) ||
               ((burst == 2'b10) &&
                !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
    endfunction

    // Address of the following beat; WRAP keeps the low bits inside the aligned window.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0] size,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] incr;
        logic [ADDR_W-1:0] wmask;
        logic [ADDR_W-1:0] sum;
        logic [ADDR_W-1:0] res;
        incr  = ADDR_W'(1) << size;
        wmask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        sum   = addr + incr;
        case (burst)
            2'b00:   res = addr;
            2'b10:   res = (addr & ~wmask) | (sum & wmask);
            default: res = sum;
        endcase
        return res;
    endfunction

    wstate_t           wstate;
    logic              wid_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wlen_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic              werr_q;
    logic              wlen_err_q;
    logic [8:0]        wcount_q;
    logic [1:0]        bresp_q;
    logic              w_hs;
    logic              wlast_mismatch;
    logic              aw_err;
    logic [IDX_W-1:0]  widx;

    rstate_t           rstate;
    logic              rid_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [7:0]        rlen_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q;
    logic              rerr_q;
    logic [7:0]        rcount_q;
    logic [63:0]       rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;
    logic              ar_err;

    assign s_axi_awready  = (wstate == W_IDLE) & ~areset;
    assign s_axi_wready   = (wstate == W_DATA) & ~areset;
    assign s_axi_bvalid   = (wstate == W_RESP) & ~areset;
    assign s_axi_bid      = wid_q;
    assign s_axi_bresp    = bresp_q;
    assign s_axi_arready  = (rstate == R_IDLE) & ~areset;
    assign s_axi_rvalid   = (rstate == R_DATA) & ~areset;
    assign s_axi_rid      = rid_q;
    assign s_axi_rdata    = rdata_q;
    assign s_axi_rresp    = rresp_q;
    assign s_axi_rlast    = rlast_q;

    assign w_hs           = s_axi_wvalid & s_axi_wready;
    assign wlast_mismatch = s_axi_wlast != (wcount_q == {1'b0, wlen_q});
    assign aw_err         = burst_err(s_axi_awlen, s_axi_awsize, s_axi_awburst);
    assign ar_err         = burst_err(s_axi_arlen, s_axi_arsize, s_axi_arburst);
    assign widx           = waddr_q[3 +: IDX_W];

    // Write engine: accept AW, stream W beats until wlast, then hold the B response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate     <= W_IDLE;
            wid_q      <= 1'b0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            werr_q     <= 1'b0;
            wlen_err_q <= 1'b0;
            wcount_q   <= '0;
            bresp_q    <= 2'b00;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (s_axi_awvalid) begin
                        wid_q      <= s_axi_awid;
                        waddr_q    <= s_axi_awaddr;
                        wlen_q     <= s_axi_awlen;
                        wsize_q    <= s_axi_awsize;
                        wburst_q   <= s_axi_awburst;
                        werr_q     <= aw_err;
                        wlen_err_q <= 1'b0;
                        wcount_q   <= '0;
                        wstate     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        if (wlast_mismatch) wlen_err_q <= 1'b1;
                        // Saturate so an overlong burst can never wrap back into the write window.
                        if (wcount_q != '1) wcount_q <= wcount_q + 9'd1;
                        waddr_q <= next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
                        if (s_axi_wlast) begin
                            bresp_q <= (werr_q || wlen_err_q || wlast_mismatch) ? 2'b10 : 2'b00;
                            wstate  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bresp_q <= 2'b00;
                        wstate  <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // RAM byte-lane writes; beats past len or in an erroneous burst are dropped.
    always_ff @(posedge aclk) begin
        if (w_hs && !werr_q && (wcount_q <= {1'b0, wlen_q})) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b]) mem[widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // Read engine: beat 0 is fetched on AR, each R handshake fetches the next beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate   <= R_IDLE;
            rid_q    <= 1'b0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rerr_q   <= 1'b0;
            rcount_q <= '0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
            rlast_q  <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        rid_q    <= s_axi_arid;
                        rlen_q   <= s_axi_arlen;
                        rsize_q  <= s_axi_arsize;
                        rburst_q <= s_axi_arburst;
                        rerr_q   <= ar_err;
                        rcount_q <= '0;
                        rdata_q  <= ar_err ? 64'd0 : mem[s_axi_araddr[3 +: IDX_W]];
                        rresp_q  <= ar_err ? 2'b10 : 2'b00;
                        rlast_q  <= (s_axi_arlen == 8'd0);
                        raddr_q  <= next_addr(s_axi_araddr, s_axi_arsize, s_axi_arlen,
                                              s_axi_arburst);
                        rstate   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (rlast_q) begin
                            rdata_q <= '0;
                            rresp_q <= 2'b00;
                            rlast_q <= 1'b0;
                            rerr_q  <= 1'b0;
                            rstate  <= R_IDLE;
                        end else begin
                            rdata_q  <= rerr_q ? 64'd0 : mem[raddr_q[3 +: IDX_W]];
                            raddr_q  <= next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
                            rcount_q <= rcount_q + 8'd1;
                            rlast_q  <= ((rcount_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave with a behavioural RAM model.
module tb_axi_mem_slave;
    localparam int DEPTH = 16;
    localparam int AW    = 32;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_axi_awid;
    logic [AW-1:0] s_axi_awaddr;
    logic [7:0]    s_axi_awlen;
    logic [2:0]    s_axi_awsize;
    logic [1:0]    s_axi_awburst;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [63:0]   s_axi_wdata;
    logic [7:0]    s_axi_wstrb;
    logic          s_axi_wlast;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic          s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic          s_axi_arid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic          s_axi_rid;
    logic [63:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready;

    always #5 aclk = ~aclk;

    axi_mem_slave #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] mem_m [DEPTH];

    logic [63:0] wr_data [0:255];
    logic [7:0]  wr_strb [0:255];
    logic        wr_last [0:255];
    int          wr_n;
    logic        b_id;
    logic [1:0]  b_resp;
    int          b_wait;

    logic [63:0] rd_data [0:255];
    logic [1:0]  rd_resp [0:255];
    logic        rd_last [0:255];
    logic        rd_id   [0:255];
    int          rd_n;
    int          rd_first;
    int          rd_stall_bad;

    function automatic bit is_err(input int len, input int size, input int burst);
        if (burst == 3 || size > 3) return 1'b1;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size,
                                              input int len, input int burst, input int i);
        logic [31:0] bytes;
        logic [31:0] wb;
        logic [31:0] base;
        bytes = 32'd1 << size;
        if (burst == 0) return start;
        if (burst == 1) return start + 32'(i) * bytes;
        wb   = 32'(len + 1) * bytes;
        base = start - (start % wb);
        return base + ((start - base + 32'(i) * bytes) % wb);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 3) % DEPTH);
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len, input int size,
                               input int burst);
        int w;
        if (is_err(len, size, burst)) return;
        for (int i = 0; i < wr_n; i++) begin
            if (i <= len) begin
                w = word_of(beat_addr(addr, size, len, burst, i));
                for (int b = 0; b < 8; b++)
                    if (wr_strb[i][b]) mem_m[w][8*b +: 8] = wr_data[i][8*b +: 8];
            end
        end
    endtask

    task automatic axi_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        int t;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        t = 0;
        while (s_axi_awready !== 1'b1 && t < 200) begin @(negedge aclk); t++; end
        if (t >= 200) begin n_checks++; $display("FAIL aw_timeout: waited %0d cycles, want <200", t); end
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < wr_n; i++) begin
            s_axi_wdata = wr_data[i]; s_axi_wstrb = wr_strb[i]; s_axi_wlast = wr_last[i];
            s_axi_wvalid = 1'b1;
            t = 0;
            while (s_axi_wready !== 1'b1 && t < 200) begin @(negedge aclk); t++; end
            if (t >= 200) begin n_checks++; $display("FAIL w_timeout: beat %0d waited %0d cycles", i, t); end
            @(negedge aclk);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b1;
        t = 0;
        while (s_axi_bvalid !== 1'b1 && t < 200) begin @(negedge aclk); t++; end
        if (t >= 200) begin n_checks++; $display("FAIL b_timeout: waited %0d cycles", t); end
        b_wait = t; b_id = s_axi_bid; b_resp = s_axi_bresp;
        @(negedge aclk);
        s_axi_bready = 1'b0;
    endtask

    // mode 0: rready always 1, mode 1: toggles 1,0,1,0..., mode 2: random
    task automatic axi_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
        int t;
        int cyc;
        bit done;
        bit stall;
        logic [63:0] pd;
        logic [1:0]  pr;
        logic        pl;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        t = 0;
        while (s_axi_arready !== 1'b1 && t < 200) begin @(negedge aclk); t++; end
        if (t >= 200) begin n_checks++; $display("FAIL ar_timeout: waited %0d cycles, want <200", t); end
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        rd_n = 0; rd_first = -1; rd_stall_bad = 0; done = 0; stall = 0; cyc = 0;
        pd = '0; pr = '0; pl = 1'b0;
        while (!done && cyc < 400) begin
            case (mode)
                0:       s_axi_rready = 1'b1;
                1:       s_axi_rready = (cyc % 2 == 0);
                default: s_axi_rready = 1'($urandom_range(0, 1));
            endcase
            if (s_axi_rvalid === 1'b1) begin
                if (rd_first < 0) rd_first = cyc;
                if (stall && (s_axi_rdata !== pd || s_axi_rresp !== pr || s_axi_rlast !== pl))
                    rd_stall_bad++;
                if (s_axi_rready) begin
                    if (rd_n < 256) begin
                        rd_data[rd_n] = s_axi_rdata; rd_resp[rd_n] = s_axi_rresp;
                        rd_last[rd_n] = s_axi_rlast; rd_id[rd_n] = s_axi_rid;
                    end
                    rd_n++;
                    stall = 0;
                    if (s_axi_rlast === 1'b1) done = 1;
                end else begin
                    stall = 1; pd = s_axi_rdata; pr = s_axi_rresp; pl = s_axi_rlast;
                end
            end
            @(negedge aclk);
            cyc++;
        end
        s_axi_rready = 1'b0;
        if (!done) begin n_checks++; $display("FAIL r_timeout: no rlast after %0d cycles, %0d beats", cyc, rd_n); end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        n_checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp, s_axi_arready,
             s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} !== 75'd0)
            $display("FAIL reset_outputs: got rdata=%h arready=%b awready=%b rvalid=%b, want all 0",
                     s_axi_rdata, s_axi_arready, s_axi_awready, s_axi_rvalid);
        else n_pass++;
        areset = 1'b0;
        @(negedge aclk);
        n_checks++;
        if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid} !== 5'b11000)
            $display("FAIL reset_release: got aw/ar/w/b/r=%b want 11000",
                     {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid});
        else n_pass++;
    endtask

    task automatic test_fill();
        wr_n = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; wr_last[i] = (i == DEPTH - 1);
        end
        axi_write(1'b0, 32'h0, 8'(DEPTH - 1), 3'd3, 2'b01);
        model_write(32'h0, DEPTH - 1, 3, 1);
        n_checks++;
        if (b_resp !== 2'b00) $display("FAIL fill_bresp: got %b want 00", b_resp); else n_pass++;
        axi_read(1'b0, 32'h0, 8'(DEPTH - 1), 3'd3, 2'b01, 0);
        n_checks++;
        if (rd_n !== DEPTH) $display("FAIL fill_beats: got %0d want %0d", rd_n, DEPTH); else n_pass++;
        for (int i = 0; i < DEPTH && i < rd_n; i++) begin
            n_checks++;
            if (rd_data[i] !== mem_m[i]) $display("FAIL fill_data[%0d]: got %h want %h", i, rd_data[i], mem_m[i]);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        wr_n = 1; wr_data[0] = 64'hDEADBEEF_CAFEF00D; wr_strb[0] = 8'hFF; wr_last[0] = 1'b1;
        axi_write(1'b1, 32'h10, 8'd0, 3'd3, 2'b01);
        model_write(32'h10, 0, 3, 1);
        n_checks++;
        if ({b_id, b_resp} !== 3'b100) $display("FAIL single_b: got id=%b resp=%b want id=1 resp=00", b_id, b_resp);
        else n_pass++;
        n_checks++;
        if (b_wait !== 0) $display("FAIL single_b_latency: got %0d extra cycles want 0", b_wait); else n_pass++;
        n_checks++;
        if (s_axi_awready !== 1'b1) $display("FAIL single_aw_turnaround: got awready=%b want 1", s_axi_awready);
        else n_pass++;
        axi_read(1'b1, 32'h10, 8'd0, 3'd3, 2'b01, 0);
        n_checks++;
        if ({rd_n == 1, rd_data[0], rd_last[0], rd_resp[0], rd_id[0]} !== {1'b1, 64'hDEADBEEF_CAFEF00D, 1'b1, 2'b00, 1'b1})
            $display("FAIL single_read: got n=%0d data=%h last=%b resp=%b id=%b want 1 DEADBEEFCAFEF00D 1 00 1",
                     rd_n, rd_data[0], rd_last[0], rd_resp[0], rd_id[0]);
        else n_pass++;
        n_checks++;
        if (rd_first !== 0) $display("FAIL single_r_latency: got %0d want 0", rd_first); else n_pass++;
    endtask

    task automatic test_incr_backpressure();
        wr_n = 4;
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 64'(i); wr_strb[i] = 8'hFF; wr_last[i] = (i == 3);
        end
        axi_write(1'b0, 32'h0, 8'd3, 3'd3, 2'b01);
        model_write(32'h0, 3, 3, 1);
        axi_read(1'b0, 32'h0, 8'd3, 3'd3, 2'b01, 1);
        n_checks++;
        if (rd_n !== 4) $display("FAIL incr_beats: got %0d want 4", rd_n); else n_pass++;
        for (int i = 0; i < 4 && i < rd_n; i++) begin
            n_checks++;
            if ({rd_data[i], rd_last[i], rd_resp[i]} !== {64'(i), (i == 3), 2'b00})
                $display("FAIL incr_beat[%0d]: got data=%h last=%b resp=%b want %0d %b 00",
                         i, rd_data[i], rd_last[i], rd_resp[i], i, (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (rd_stall_bad !== 0) $display("FAIL incr_stall_stable: got %0d changes want 0", rd_stall_bad);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [63:0] exp_w [0:3];
        exp_w[0] = 64'd3; exp_w[1] = 64'd0; exp_w[2] = 64'd1; exp_w[3] = 64'd2;
        axi_read(1'b1, 32'h18, 8'd3, 3'd3, 2'b10, 0);
        n_checks++;
        if (rd_n !== 4) $display("FAIL wrap_beats: got %0d want 4", rd_n); else n_pass++;
        for (int i = 0; i < 4 && i < rd_n; i++) begin
            n_checks++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {exp_w[i], 2'b00, (i == 3)})
                $display("FAIL wrap_beat[%0d]: got data=%h resp=%b last=%b want %h 00 %b",
                         i, rd_data[i], rd_resp[i], rd_last[i], exp_w[i], (i == 3));
            else n_pass++;
        end
        axi_read(1'b1, 32'h18, 8'd2, 3'd3, 2'b10, 2);
        n_checks++;
        if (rd_n !== 3) $display("FAIL wrap_bad_beats: got %0d want 3", rd_n); else n_pass++;
        for (int i = 0; i < 3 && i < rd_n; i++) begin
            n_checks++;
            if ({rd_data[i], rd_resp[i]} !== {64'd0, 2'b10})
                $display("FAIL wrap_bad_beat[%0d]: got data=%h resp=%b want 0 10", i, rd_data[i], rd_resp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_strobe_reserved();
        wr_n = 1; wr_data[0] = '1; wr_strb[0] = 8'hFF; wr_last[0] = 1'b1;
        axi_write(1'b0, 32'h28, 8'd0, 3'd3, 2'b01);
        model_write(32'h28, 0, 3, 1);
        wr_data[0] = '0; wr_strb[0] = 8'h0F;
        axi_write(1'b0, 32'h28, 8'd0, 3'd3, 2'b01);
        model_write(32'h28, 0, 3, 1);
        axi_read(1'b0, 32'h28, 8'd0, 3'd3, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 64'hFFFFFFFF_00000000)
            $display("FAIL strobe_data: got %h want FFFFFFFF00000000", rd_data[0]);
        else n_pass++;
        wr_strb[0] = 8'hFF;
        axi_write(1'b1, 32'h28, 8'd0, 3'd3, 2'b11);
        n_checks++;
        if ({b_id, b_resp} !== 3'b110) $display("FAIL reserved_bresp: got id=%b resp=%b want 1 10", b_id, b_resp);
        else n_pass++;
        axi_read(1'b0, 32'h28, 8'd0, 3'd3, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 64'hFFFFFFFF_00000000)
            $display("FAIL reserved_ram: got %h want FFFFFFFF00000000", rd_data[0]);
        else n_pass++;
    endtask

    task automatic test_wlast_mismatch();
        wr_n = 2;
        wr_data[0] = 64'hA0A0; wr_data[1] = 64'hB1B1;
        wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF; wr_last[0] = 1'b0; wr_last[1] = 1'b1;
        axi_write(1'b1, 32'h40, 8'd3, 3'd3, 2'b01);
        model_write(32'h40, 3, 3, 1);
        n_checks++;
        if ({b_resp, b_wait} !== {2'b10, 32'd0})
            $display("FAIL early_wlast: got resp=%b bwait=%0d want 10 0", b_resp, b_wait);
        else n_pass++;
        n_checks++;
        if (s_axi_awready !== 1'b1) $display("FAIL early_wlast_turnaround: got awready=%b want 1", s_axi_awready);
        else n_pass++;
        wr_n = 3;
        wr_data[0] = 64'h1111; wr_data[1] = 64'h2222; wr_data[2] = 64'h3333;
        wr_strb[2] = 8'hFF; wr_last[0] = 1'b0; wr_last[1] = 1'b0; wr_last[2] = 1'b1;
        axi_write(1'b0, 32'h60, 8'd0, 3'd3, 2'b01);
        model_write(32'h60, 0, 3, 1);
        n_checks++;
        if (b_resp !== 2'b10) $display("FAIL late_wlast_bresp: got %b want 10", b_resp); else n_pass++;
        axi_read(1'b0, 32'h60, 8'd1, 3'd3, 2'b01, 0);
        n_checks++;
        if ({rd_data[0], rd_data[1]} !== {mem_m[12], mem_m[13]})
            $display("FAIL late_wlast_ram: got %h %h want %h %h", rd_data[0], rd_data[1], mem_m[12], mem_m[13]);
        else n_pass++;
    endtask

    task automatic test_read_before_write();
        logic [63:0] old_v;
        old_v = mem_m[9];
        wr_n = 1; wr_data[0] = {$urandom, $urandom}; wr_strb[0] = 8'hFF; wr_last[0] = 1'b1;
        fork
            axi_write(1'b0, 32'h48, 8'd0, 3'd3, 2'b01);
            begin
                @(negedge aclk);
                axi_read(1'b1, 32'h48, 8'd0, 3'd3, 2'b01, 0);
            end
        join
        model_write(32'h48, 0, 3, 1);
        n_checks++;
        if (rd_data[0] !== old_v) $display("FAIL rbw_old: got %h want %h", rd_data[0], old_v); else n_pass++;
        axi_read(1'b1, 32'h48, 8'd0, 3'd3, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== mem_m[9]) $display("FAIL rbw_new: got %h want %h", rd_data[0], mem_m[9]); else n_pass++;
    endtask

    task automatic gen_burst(output logic [31:0] addr, output int len, output int size,
                             output int burst);
        int lens [4];
        lens[0] = 1; lens[1] = 3; lens[2] = 7; lens[3] = 15;
        addr  = $urandom;
        size  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
        burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        if (burst == 2) len = ($urandom_range(0, 7) == 0) ? 2 : lens[$urandom_range(0, 3)];
        else len = int'($urandom_range(0, 7));
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int len, size, burst, w;
        logic id;
        bit err;
        logic [63:0] ed;
        for (int it = 0; it < 40; it++) begin
            gen_burst(addr, len, size, burst);
            id = 1'($urandom_range(0, 1));
            wr_n = len + 1;
            for (int i = 0; i <= len; i++) begin
                wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'($urandom); wr_last[i] = (i == len);
            end
            axi_write(id, addr, 8'(len), 3'(size), 2'(burst));
            model_write(addr, len, size, burst);
            n_checks++;
            if ({b_id, b_resp} !== {id, is_err(len, size, burst) ? 2'b10 : 2'b00})
                $display("FAIL rand_b[%0d]: got id=%b resp=%b want id=%b err=%b", it, b_id, b_resp, id, is_err(len, size, burst));
            else n_pass++;
            gen_burst(addr, len, size, burst);
            id = 1'($urandom_range(0, 1));
            err = is_err(len, size, burst);
            axi_read(id, addr, 8'(len), 3'(size), 2'(burst), 2);
            n_checks++;
            if (rd_n !== len + 1) $display("FAIL rand_r_beats[%0d]: got %0d want %0d", it, rd_n, len + 1);
            else n_pass++;
            for (int i = 0; i <= len && i < rd_n; i++) begin
                w  = word_of(beat_addr(addr, size, len, burst, i));
                ed = err ? 64'd0 : mem_m[w];
                n_checks++;
                if ({rd_data[i], rd_resp[i], rd_last[i], rd_id[i]} !== {ed, err ? 2'b10 : 2'b00, (i == len), id})
                    $display("FAIL rand_r[%0d][%0d]: got data=%h resp=%b last=%b id=%b want %h err=%b last=%b id=%b",
                             it, i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], ed, err, (i == len), id);
                else n_pass++;
            end
            n_checks++;
            if (rd_stall_bad !== 0) $display("FAIL rand_stall[%0d]: got %0d changes want 0", it, rd_stall_bad);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst();
        int t;
        s_axi_arid = 1'b1; s_axi_araddr = 32'h0; s_axi_arlen = 8'd3;
        s_axi_arsize = 3'd3; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        t = 0;
        while (s_axi_arready !== 1'b1 && t < 200) begin @(negedge aclk); t++; end
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        @(negedge aclk);
        n_checks++;
        if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, mem_m[1]})
            $display("FAIL mid_beat1: got rvalid=%b data=%h want 1 %h", s_axi_rvalid, s_axi_rdata, mem_m[1]);
        else n_pass++;
        areset = 1'b1; s_axi_rready = 1'b0;
        @(negedge aclk);
        n_checks++;
        if ({s_axi_rvalid, s_axi_arready, s_axi_rlast, s_axi_rid, s_axi_rdata} !== 68'd0)
            $display("FAIL mid_reset: got rvalid=%b arready=%b rlast=%b rid=%b rdata=%h want all 0",
                     s_axi_rvalid, s_axi_arready, s_axi_rlast, s_axi_rid, s_axi_rdata);
        else n_pass++;
        areset = 1'b0;
        @(negedge aclk);
        n_checks++;
        if ({s_axi_arready, s_axi_rvalid} !== 2'b10)
            $display("FAIL mid_release: got arready=%b rvalid=%b want 1 0", s_axi_arready, s_axi_rvalid);
        else n_pass++;
        axi_read(1'b0, 32'h8, 8'd2, 3'd3, 2'b01, 0);
        n_checks++;
        if ({rd_n == 3, rd_data[0], rd_data[1], rd_data[2], rd_last[2]} !== {1'b1, mem_m[1], mem_m[2], mem_m[3], 1'b1})
            $display("FAIL mid_after: got n=%0d data=%h %h %h want %h %h %h",
                     rd_n, rd_data[0], rd_data[1], rd_data[2], mem_m[1], mem_m[2], mem_m[3]);
        else n_pass++;
    endtask

    initial begin
        areset = 1'b1;
        s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
        s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_wvalid = 0;
        s_axi_bready = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0;
        s_axi_arburst = 0; s_axi_arvalid = 0; s_axi_rready = 0;
        test_reset();
        test_fill();
        test_single();
        test_incr_backpressure();
        test_wrap();
        test_strobe_reserved();
        test_wlast_mismatch();
        test_read_before_write();
        test_random();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
